// File: rtl/sr_cmd_pkg.sv
// sr_cmd_pkg: shared types and constants for the SR command debouncer.
package sr_cmd_pkg;

  // Debounce FSM states. The encoding keeps bit 1 equal to the debounced
  // level that the state is holding or leaving.
  typedef enum logic [1:0] {
    STABLE0 = 2'b00,
    PEND1   = 2'b01,
    STABLE1 = 2'b11,
    PEND0   = 2'b10
  } db_state_e;

  // Number of flops in each input synchronizer.
  localparam int SYNC_STAGES = 2;

endpackage : sr_cmd_pkg

// File: rtl/sr_debounce_ch.sv
// sr_debounce_ch: one debounce channel.
// Raw input -> 2-flop synchronizer -> debounce FSM with a saturating
// qualification counter -> registered debounced level.
module sr_debounce_ch
  import sr_cmd_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_level
);

  localparam logic [CNT_W-1:0] DB_MAX = CNT_W'(DEBOUNCE_CYCLES);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_synced;

  db_state_e              r_state;
  db_state_e              w_state_nxt;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       w_cnt_nxt;
  logic                   r_level;
  logic                   w_level_nxt;

  // Synchronizer shift register; the last stage is the synced value.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values of its neighbours, giving a true shift register.
  always_ff @(posedge clk) begin
    if (rst) r_sync <= '0;
    else     r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
  end

  assign w_synced = r_sync[SYNC_STAGES-1];

  // Next-state, counter and level decode for the debounce FSM.
  // NOTE: every output is defaulted to its held value first, so no path
  // through the case leaves a signal unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_level_nxt = r_level;
    unique case (r_state)
      STABLE0: begin
        if (w_synced) begin
          w_state_nxt = PEND1;
          w_cnt_nxt   = CNT_W'(1);
        end
      end
      PEND1: begin
        if (!w_synced) begin
          w_state_nxt = STABLE0;   // bounce rejected
          w_cnt_nxt   = '0;
        end else if (r_cnt == DB_MAX) begin
          w_state_nxt = STABLE1;
          w_cnt_nxt   = '0;
          w_level_nxt = 1'b1;
        end else begin
          w_cnt_nxt   = r_cnt + CNT_W'(1);
        end
      end
      STABLE1: begin
        if (!w_synced) begin
          w_state_nxt = PEND0;
          w_cnt_nxt   = CNT_W'(1);
        end
      end
      PEND0: begin
        if (w_synced) begin
          w_state_nxt = STABLE1;   // bounce rejected
          w_cnt_nxt   = '0;
        end else if (r_cnt == DB_MAX) begin
          w_state_nxt = STABLE0;
          w_cnt_nxt   = '0;
          w_level_nxt = 1'b0;
        end else begin
          w_cnt_nxt   = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = STABLE0;
        w_cnt_nxt   = '0;
        w_level_nxt = 1'b0;
      end
    endcase
  end

  // FSM state, counter and level registers; reset discards any pending count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= STABLE0;
      r_cnt   <= '0;
      r_level <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_level <= w_level_nxt;
    end
  end

  assign o_level = r_level;

endmodule : sr_debounce_ch

// File: rtl/sr_cmd_debouncer.sv
// sr_cmd_debouncer: turns two bouncy push buttons (SET, RESET) into
// single-cycle s/r command pulses for a clocked SR latch.
// Optional macro SR_CMD_RESET_PRIORITY_EN: on a simultaneous rise, issue
// r_o (reset wins) instead of suppressing both pulses. conflict_o is
// raised in both builds, and s_o and r_o are never high together.
module sr_cmd_debouncer
  import sr_cmd_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic set_btn_i,
  input  logic rst_btn_i,
  output logic s_o,
  output logic r_o,
  output logic set_lvl_o,
  output logic rst_lvl_o,
  output logic conflict_o
);

  logic w_set_lvl;
  logic w_rst_lvl;
  logic r_set_lvl_q;
  logic r_rst_lvl_q;
  logic w_set_rise;
  logic w_rst_rise;
  logic w_s_nxt;
  logic w_r_nxt;
  logic w_conflict_nxt;
  logic r_s;
  logic r_r;
  logic r_conflict;

  sr_debounce_ch #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_set_ch (
    .clk     (clk),
    .rst     (rst),
    .i_raw   (set_btn_i),
    .o_level (w_set_lvl)
  );

  sr_debounce_ch #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_rst_ch (
    .clk     (clk),
    .rst     (rst),
    .i_raw   (rst_btn_i),
    .o_level (w_rst_lvl)
  );

  // Delayed copies of the debounced levels for rising-edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_set_lvl_q <= 1'b0;
      r_rst_lvl_q <= 1'b0;
    end else begin
      r_set_lvl_q <= w_set_lvl;
      r_rst_lvl_q <= w_rst_lvl;
    end
  end

  assign w_set_rise = w_set_lvl & ~r_set_lvl_q;
  assign w_rst_rise = w_rst_lvl & ~r_rst_lvl_q;

  // Arbitration of same-edge rises; releases never produce a pulse.
  always_comb begin
    w_conflict_nxt = w_set_rise & w_rst_rise;
    w_s_nxt        = w_set_rise & ~w_rst_rise;
`ifdef SR_CMD_RESET_PRIORITY_EN
    w_r_nxt        = w_rst_rise;
`else
    w_r_nxt        = w_rst_rise & ~w_set_rise;
`endif
  end

  // Registered command pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s        <= 1'b0;
      r_r        <= 1'b0;
      r_conflict <= 1'b0;
    end else begin
      r_s        <= w_s_nxt;
      r_r        <= w_r_nxt;
      r_conflict <= w_conflict_nxt;
    end
  end

  assign s_o        = r_s;
  assign r_o        = r_r;
  assign conflict_o = r_conflict;
  assign set_lvl_o  = w_set_lvl;
  assign rst_lvl_o  = w_rst_lvl;

endmodule : sr_cmd_debouncer

// File: tb/tb_sr_cmd_debouncer.sv
// tb_sr_cmd_debouncer: directed bench for sr_cmd_debouncer, DEBOUNCE_CYCLES=4.
// Edge numbering: edge 0 is the first rising edge that samples a new raw
// value (or the first edge with rst low after a reset). With 4 qualifying
// edges the debounced level rises at edge 6 and the command pulse appears
// at edge 7.
module tb_sr_cmd_debouncer;

  localparam int DB = 4;
`ifdef SR_CMD_RESET_PRIORITY_EN
  localparam bit RST_PRI = 1'b1;
`else
  localparam bit RST_PRI = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic set_btn_i;
  logic rst_btn_i;
  logic s_o;
  logic r_o;
  logic set_lvl_o;
  logic rst_lvl_o;
  logic conflict_o;

  int n_vec  = 0;
  int n_miss = 0;

  sr_cmd_debouncer #(
    .DEBOUNCE_CYCLES (DB),
    .CNT_W           (5)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .set_btn_i  (set_btn_i),
    .rst_btn_i  (rst_btn_i),
    .s_o        (s_o),
    .r_o        (r_o),
    .set_lvl_o  (set_lvl_o),
    .rst_lvl_o  (rst_lvl_o),
    .conflict_o (conflict_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic got, input logic exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One rising edge, then settle so outputs are sampled away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    rst       = 1'b1;
    set_btn_i = 1'b0;
    rst_btn_i = 1'b0;
    #1;

    // 1. Reset held 3 edges with SET already pressed: everything stays 0.
    set_btn_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("rst_s",        s_o,        1'b0);
      check("rst_r",        r_o,        1'b0);
      check("rst_set_lvl",  set_lvl_o,  1'b0);
      check("rst_rst_lvl",  rst_lvl_o,  1'b0);
      check("rst_conflict", conflict_o, 1'b0);
    end
    rst = 1'b0;
    for (int k = 0; k <= 12; k++) begin
      step();
      check("post_rst_s",   s_o,       (k == 7));
      check("post_rst_lvl", set_lvl_o, (k >= 6));
    end

    // Release: level falls 6 edges later, no pulse.
    set_btn_i = 1'b0;
    for (int k = 0; k <= 9; k++) begin
      step();
      check("rel_lvl", set_lvl_o, (k < 6));
      check("rel_s",   s_o,       1'b0);
    end

    // 2. Bounce reject: toggle every edge for 8 edges, then stay low.
    for (int k = 0; k < 16; k++) begin
      set_btn_i = (k < 8) ? ~k[0] : 1'b0;
      step();
      check("bounce_lvl", set_lvl_o, 1'b0);
      check("bounce_s",   s_o,       1'b0);
    end

    // 3. Clean press held 40 edges: one pulse only.
    set_btn_i = 1'b1;
    for (int k = 0; k < 40; k++) begin
      step();
      check("hold_s",   s_o,       (k == 7));
      check("hold_lvl", set_lvl_o, (k >= 6));
      check("hold_r",   r_o,       1'b0);
    end
    set_btn_i = 1'b0;
    for (int k = 0; k <= 9; k++) begin
      step();
      check("hold_rel_lvl", set_lvl_o, (k < 6));
      check("hold_rel_s",   s_o,       1'b0);
    end

    // 4. Simultaneous press.
    set_btn_i = 1'b1;
    rst_btn_i = 1'b1;
    for (int k = 0; k <= 12; k++) begin
      step();
      check("sim_conflict", conflict_o, (k == 7));
      check("sim_s",        s_o,        1'b0);
      check("sim_r",        r_o,        (k == 7) && RST_PRI);
      check("sim_rst_lvl",  rst_lvl_o,  (k >= 6));
    end
    set_btn_i = 1'b0;
    rst_btn_i = 1'b0;
    idle(10);
    check("sim_rel_set_lvl", set_lvl_o, 1'b0);
    check("sim_rel_rst_lvl", rst_lvl_o, 1'b0);

    // 5. Staggered: RESET raw rises 2 edges after SET.
    set_btn_i = 1'b1;
    for (int k = 0; k <= 14; k++) begin
      rst_btn_i = (k >= 2);
      step();
      check("stag_s",        s_o,             (k == 7));
      check("stag_r",        r_o,             (k == 9));
      check("stag_conflict", conflict_o,      1'b0);
      check("stag_excl",     s_o & r_o,       1'b0);
    end
    set_btn_i = 1'b0;
    rst_btn_i = 1'b0;
    idle(10);

    // 6. Reset pulsed at edge 4 during qualification: count restarts.
    set_btn_i = 1'b1;
    for (int k = 0; k <= 16; k++) begin
      rst = (k == 4);
      step();
      check("midrst_s",   s_o,       (k == 12));
      check("midrst_lvl", set_lvl_o, (k >= 11));
    end
    rst       = 1'b0;
    set_btn_i = 1'b0;
    idle(10);
    check("final_lvl", set_lvl_o, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule : tb_sr_cmd_debouncer
